// File: rtl/clk_rst_ctl_pkg.sv
// Shared state encodings, reset-cause codes and small helpers for the
// clock/reset sequencer.
package clk_rst_ctl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_QUIESCE   = 3'd4,
        ST_SETTLE    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_EXT  = 2'b01,
        CAUSE_SW   = 2'b10,
        CAUSE_LOCK = 2'b11
    } cause_e;

    localparam int CFG_W = 7;

    // RCFAST is the safe configuration the core always restarts from.
    localparam logic [CFG_W-1:0] CFG_RCFAST = '0;

    localparam int QUIESCE_CYCLES = 2;

    function automatic logic holds_core_res(input state_e st);
        return (st == ST_RESET) || (st == ST_WAIT_LOCK) || (st == ST_HOLD);
    endfunction

    function automatic logic gives_clk_en(input state_e st);
        return (st == ST_RUN);
    endfunction

endpackage

// File: rtl/clk_rst_ctl_sync_deb.sv
// Two-flop synchronizer with an optional level debouncer; DEB_CYCLES=0
// bypasses the debouncer and exposes the synchronized level directly.
module clk_rst_ctl_sync_deb #(
    parameter logic        RST_VAL    = 1'b0,
    parameter int unsigned DEB_CYCLES = 0,
    parameter int unsigned CNT_W      = 24
) (
    input  logic clk,
    input  logic nres,
    input  logic i_async,
    output logic o_level
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
        end
    end

    generate
        if (DEB_CYCLES == 0) begin : g_nodeb
            assign o_level = r_s2;
        end else begin : g_deb
            localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

            logic             r_level;
            logic [CNT_W-1:0] r_cnt;

            // Count only while the input disagrees with the accepted level;
            // any return to agreement restarts the window.
            always_ff @(posedge clk or negedge nres) begin
                if (!nres) begin
                    r_level <= RST_VAL;
                    r_cnt   <= '0;
                end else if (r_s2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == DEB_LAST) begin
                    r_level <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign o_level = r_level;
        end
    endgenerate

endmodule

// File: rtl/clk_rst_ctl.sv
// Reset and clock-configuration sequencer: holds the core in reset until the
// PLL is locked and stable, and gates the cog clock around config switches.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   RESET      | just out of nres, core held in reset
//   WAIT_LOCK  | core in reset, waiting for lock and no external reset
//   HOLD       | lock seen, counting out the reset hold time
//   RUN        | core running, clock enabled
//   QUIESCE    | clock stopped, waiting before applying new config
//   SETTLE     | new config applied, clock stopped while it settles
module clk_rst_ctl
    import clk_rst_ctl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 16,
    parameter int unsigned HOLD_CYCLES   = 1024,
    parameter int unsigned SETTLE_CYCLES = 16384,
    parameter int unsigned CNT_W         = 24
) (
    input  logic             clk,
    input  logic             nres,
    input  logic             ext_resn,
    input  logic             pll_locked,
    input  logic             sw_res,
    input  logic [CFG_W-1:0] cfg_in,
    output logic             core_res,
    output logic             clk_en,
    output logic [CFG_W-1:0] cfg_out,
    output logic [1:0]       res_cause,
    output logic [2:0]       state
);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] QUIESCE_LAST = CNT_W'(QUIESCE_CYCLES - 1);

    logic w_ext_level;
    logic w_ext_res_d;
    logic w_lock_s;

    clk_rst_ctl_sync_deb #(
        .RST_VAL    (1'b1),
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_sync_ext (
        .clk     (clk),
        .nres    (nres),
        .i_async (ext_resn),
        .o_level (w_ext_level)
    );

    clk_rst_ctl_sync_deb #(
        .RST_VAL    (1'b0),
        .DEB_CYCLES (0),
        .CNT_W      (CNT_W)
    ) u_sync_lock (
        .clk     (clk),
        .nres    (nres),
        .i_async (pll_locked),
        .o_level (w_lock_s)
    );

    assign w_ext_res_d = ~w_ext_level;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CFG_W-1:0] r_cfg_out;
    cause_e           r_cause;
    logic             r_core_res;
    logic             r_clk_en;

    logic             w_rst_req;
    cause_e           w_rst_cause;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CFG_W-1:0] w_cfg_nxt;
    cause_e           w_cause_nxt;

    // Reset requests in priority order; software reboot only counts in RUN.
    always_comb begin
        w_rst_req   = 1'b0;
        w_rst_cause = CAUSE_POR;
        if (w_ext_res_d) begin
            w_rst_req   = 1'b1;
            w_rst_cause = CAUSE_EXT;
        end else if (!w_lock_s) begin
            w_rst_req   = 1'b1;
            w_rst_cause = CAUSE_LOCK;
        end else if (sw_res && (r_state == ST_RUN)) begin
            w_rst_req   = 1'b1;
            w_rst_cause = CAUSE_SW;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cfg_nxt   = r_cfg_out;
        w_cause_nxt = r_cause;

        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end

            ST_WAIT_LOCK: begin
                if (w_lock_s && !w_ext_res_d) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end
            end

            ST_HOLD: begin
                if (!w_lock_s || w_ext_res_d) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (w_rst_req) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_cfg_nxt   = CFG_RCFAST;
                    w_cause_nxt = w_rst_cause;
                end else if (cfg_in != r_cfg_out) begin
                    w_state_nxt = ST_QUIESCE;
                    w_cnt_nxt   = '0;
                end
            end

            ST_QUIESCE: begin
                if (w_rst_req) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_cfg_nxt   = CFG_RCFAST;
                    w_cause_nxt = w_rst_cause;
                end else if (r_cnt == QUIESCE_LAST) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = '0;
                    w_cfg_nxt   = cfg_in;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_SETTLE: begin
                if (w_rst_req) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_cfg_nxt   = CFG_RCFAST;
                    w_cause_nxt = w_rst_cause;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_RESET;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself and never glitch.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            r_state    <= ST_RESET;
            r_cnt      <= '0;
            r_cfg_out  <= CFG_RCFAST;
            r_cause    <= CAUSE_POR;
            r_core_res <= 1'b1;
            r_clk_en   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cfg_out  <= w_cfg_nxt;
            r_cause    <= w_cause_nxt;
            r_core_res <= holds_core_res(w_state_nxt);
            r_clk_en   <= gives_clk_en(w_state_nxt);
        end
    end

    assign core_res  = r_core_res;
    assign clk_en    = r_clk_en;
    assign cfg_out   = r_cfg_out;
    assign res_cause = r_cause;
    assign state     = r_state;

endmodule
